clock_step_controller: RTL and testbench
========================================

CLOCK_STEP_CONTROLLER -- requirements
Module: clock_step_controller

Interface
REQ-001 SHALL have parameter DIV_LIMIT, default 12499999: divider terminal count; one processor-enable pulse every DIV_LIMIT+1 inclk0 cycles.
REQ-002 SHALL have parameter CNT_W, default 32: width of the divider and tick counters.
REQ-003 SHALL have port inclk0  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port run  input  1  level request for free-running mode.
REQ-006 SHALL have port step_req  input  1  request for exactly one processor-enable pulse.
REQ-007 SHALL have port halt  input  1  level stop request; highest priority.
REQ-008 SHALL have port cpu_en  output  1  registered one-cycle processor clock-enable pulse.
REQ-009 SHALL have port step_ack  output  1  registered one-cycle completion pulse for a step.
REQ-010 SHALL have port state  output  2  current FSM state encoding.
REQ-011 SHALL have port busy  output  1  high while state is RUN or STEP.
REQ-012 SHALL have port tick_count  output  CNT_W  number of cpu_en pulses issued since reset.

Function
REQ-013 SHALL implement states IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11.
REQ-014 SHALL keep an internal divider div_cnt of CNT_W bits, cleared to 0 on every entry to RUN or STEP.
REQ-015 In RUN or STEP, SHALL set div_cnt to div_cnt+1 and cpu_en to 0 on each edge where div_cnt < DIV_LIMIT.
REQ-016 On an edge where div_cnt == DIV_LIMIT, SHALL set div_cnt to 0, set cpu_en to 1 for one cycle, and increment tick_count.
REQ-017 SHALL make the first cpu_en pulse go high DIV_LIMIT+1 edges after the edge that entered RUN or STEP; in RUN, subsequent pulses SHALL have period DIV_LIMIT+1.
REQ-018 With DIV_LIMIT=0, SHALL hold cpu_en high on every cycle in RUN.
REQ-019 IDLE transitions, evaluated in priority order halt > run > step_req: halt goes to HALTED, run goes to RUN, step_req goes to STEP; with no request, state SHALL remain IDLE.
REQ-020 RUN transitions: halt goes to HALTED; run low goes to IDLE on that edge with no pulse; step_req SHALL be ignored.
REQ-021 STEP SHALL go to IDLE on the terminal-count edge, asserting cpu_en and step_ack together for one cycle.
REQ-022 In STEP, halt SHALL abort to HALTED with no cpu_en, no step_ack, and no tick_count change; run and step_req SHALL be ignored.
REQ-023 HALTED SHALL go to IDLE only on an edge where halt, run, and step_req are all 0; otherwise it SHALL remain HALTED.
REQ-024 cpu_en and step_ack SHALL be 0 in every cycle not covered by REQ-016 and REQ-021, including all cycles in IDLE and HALTED.
REQ-025 tick_count SHALL wrap from 2^CNT_W-1 to 0 without any other effect.
REQ-026 On halt rising in the same edge as a terminal count, halt SHALL win: no pulse is issued and tick_count is unchanged.

Reset
REQ-027 On an edge with reset=1, SHALL set state=IDLE, div_cnt=0, cpu_en=0, step_ack=0, and tick_count=0, overriding all other inputs.
REQ-028 Reset asserted mid-RUN or mid-STEP SHALL abandon the partial count; no pulse or acknowledge is issued after reset.
REQ-029 busy SHALL be 0 in the cycle after a reset edge.

Verification (DIV_LIMIT=3)
REQ-030 Free-run: run=1 sampled at edge 0 -> cpu_en high after edges 4, 8, and 12 only; tick_count=3 after edge 12; state=01 throughout.
REQ-031 Single step: 1-cycle step_req at edge 0 in IDLE -> cpu_en and step_ack both high after edge 4 only; state 10 then 00; tick_count=1.
REQ-032 Halt priority: halt, run, and step_req all high at edge 0 -> state=11; after all drop at edge 5 -> state=00 with no cpu_en pulse.
REQ-033 Step abort: step_req at edge 0 and halt at edge 3 -> state=11 after edge 3; cpu_en, step_ack, and tick_count stay 0.
REQ-034 Reset mid-run: run=1 from edge 0 and reset at edge 6 -> all outputs 0 and state=00 after edge 6; with run held high and reset released, the next cpu_en follows edge 11.
REQ-035 Wrap: with CNT_W=4 and 16 pulses issued in RUN -> tick_count reads 15 then 0.

Source files
------------

// File: rtl/clock_step_controller.sv
// clock_step_controller: divided processor clock-enable generator with run/step/halt control.
module clock_step_controller #(
   parameter int DIV_LIMIT = 12499999,
   parameter int CNT_W = 32
) (
   input  logic             inclk0,
   input  logic             reset,
   input  logic             run,
   input  logic             step_req,
   input  logic             halt,
   output logic             cpu_en,
   output logic             step_ack,
   output logic [1:0]       state,
   output logic             busy,
   output logic [CNT_W-1:0] tick_count
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALTED = 2'b11} state_t;
   localparam logic [CNT_W-1:0] LIM = CNT_W'(DIV_LIMIT);
   state_t st;
   logic [CNT_W-1:0] div_cnt;
   logic term;
   assign term = div_cnt == LIM;
   assign state = st;
   assign busy = st == RUN || st == STEP;
   // The divider is held at zero in IDLE, so every entry to RUN or STEP starts a fresh count.
   always_ff @(posedge inclk0) begin
      cpu_en <= 1'b0;
      step_ack <= 1'b0;
      if (reset) begin
         st <= IDLE;
         div_cnt <= '0;
         tick_count <= '0;
      end else begin
         case (st)
            IDLE: begin
               div_cnt <= '0;
               st <= halt ? HALTED : run ? RUN : step_req ? STEP : IDLE;
            end
            RUN, STEP: begin
               if (halt) st <= HALTED;
               else if (st == RUN && !run) st <= IDLE;
               else if (term) begin
                  div_cnt <= '0;
                  cpu_en <= 1'b1;
                  tick_count <= tick_count + 1'b1;
                  if (st == STEP) begin
                     step_ack <= 1'b1;
                     st <= IDLE;
                  end
               end else div_cnt <= div_cnt + 1'b1;
            end
            default: if (!halt && !run && !step_req) st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_clock_step_controller.sv
// tb_clock_step_controller: scoreboard bench comparing two divider settings against a mode/phase model.
module tb_clock_step_controller;
   logic inclk0 = 0, reset, run, step_req, halt;
   logic en3, ack3, busy3, en0, ack0, busy0;
   logic [1:0] st3, st0;
   logic [3:0] tc3, tc0;
   int checks = 0, errors = 0;

   typedef struct {
      int mode;
      int since;
      int ticks;
      bit en;
      bit ack;
   } mdl_t;

   mdl_t m3 = '{0, 0, 0, 0, 0}, m0 = '{0, 0, 0, 0, 0};
   mdl_t q3[$], q0[$];

   clock_step_controller #(.DIV_LIMIT(3), .CNT_W(4)) u3 (
      .inclk0(inclk0), .reset(reset), .run(run), .step_req(step_req), .halt(halt),
      .cpu_en(en3), .step_ack(ack3), .state(st3), .busy(busy3), .tick_count(tc3));
   clock_step_controller #(.DIV_LIMIT(0), .CNT_W(4)) u0 (
      .inclk0(inclk0), .reset(reset), .run(run), .step_req(step_req), .halt(halt),
      .cpu_en(en0), .step_ack(ack0), .state(st0), .busy(busy0), .tick_count(tc0));

   always #5 inclk0 = ~inclk0;

   // Modes: 0 idle, 1 run, 2 step, 3 halted; a pulse falls on every (l+1)-th edge since entry.
   function automatic mdl_t nxt(mdl_t m, int l, bit rs, bit r, bit s, bit h);
      mdl_t n = m;
      n.en = 0;
      n.ack = 0;
      if (rs) n = '{0, 0, 0, 0, 0};
      else if (m.mode == 0) begin
         n.since = 0;
         n.mode = h ? 3 : r ? 1 : s ? 2 : 0;
      end else if (m.mode == 3) n.mode = (!h && !r && !s) ? 0 : 3;
      else if (h) n.mode = 3;
      else if (m.mode == 1 && !r) n.mode = 0;
      else begin
         n.since = m.since + 1;
         if (n.since % (l + 1) == 0) begin
            n.en = 1;
            n.ticks = (m.ticks + 1) % 16;
            if (m.mode == 2) begin
               n.ack = 1;
               n.mode = 0;
            end
         end
      end
      return n;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge inclk0) begin
      m3 = nxt(m3, 3, reset, run, step_req, halt);
      m0 = nxt(m0, 0, reset, run, step_req, halt);
      q3.push_back(m3);
      q0.push_back(m0);
   end

   always @(negedge inclk0) begin
      mdl_t e;
      if (q3.size() > 0) begin
         e = q3.pop_front();
         chk("l3_cpu_en", int'(en3), int'(e.en));
         chk("l3_step_ack", int'(ack3), int'(e.ack));
         chk("l3_state", int'(st3), e.mode);
         chk("l3_busy", int'(busy3), int'(e.mode == 1 || e.mode == 2));
         chk("l3_tick_count", int'(tc3), e.ticks);
      end
      if (q0.size() > 0) begin
         e = q0.pop_front();
         chk("l0_cpu_en", int'(en0), int'(e.en));
         chk("l0_step_ack", int'(ack0), int'(e.ack));
         chk("l0_state", int'(st0), e.mode);
         chk("l0_busy", int'(busy0), int'(e.mode == 1 || e.mode == 2));
         chk("l0_tick_count", int'(tc0), e.ticks);
      end
   end

   task automatic cyc(bit rs, bit r, bit s, bit h, int n = 1);
      reset = rs;
      run = r;
      step_req = s;
      halt = h;
      repeat (n) @(negedge inclk0);
   endtask

   initial begin
      bit r = 0;
      cyc(1, 0, 0, 0, 2);
      cyc(0, 1, 0, 0, 13);
      cyc(0, 0, 0, 0, 2);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0, 6);
      cyc(0, 1, 1, 1, 5);
      cyc(0, 0, 0, 0, 6);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0, 2);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0, 4);
      cyc(0, 1, 0, 0, 6);
      cyc(0, 1, 0, 1);
      cyc(0, 1, 0, 0, 3);
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0, 8);
      cyc(0, 1, 0, 0, 70);
      cyc(0, 1, 0, 0, 3);
      cyc(0, 1, 0, 1);
      cyc(0, 0, 0, 0, 3);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) r = ~r;
         cyc($urandom_range(63) == 0, r, $urandom_range(5) == 0, $urandom_range(11) == 0);
      end
      cyc(0, 0, 0, 0, 3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
